// File: rtl/sosanh_sort_ctrl.sv
// In-place ascending bubble sorter over an N x W register file, one shared comparator.
// Optional swap counter output enabled by defining SOSANH_SWAP_CNT_EN.
module sosanh_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [W-1:0]         wr_data,
  input  logic                 start,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [W-1:0]         rd_data,
  output logic                 busy,
`ifdef SOSANH_SWAP_CNT_EN
  output logic [7:0]           swap_cnt,
`endif
  output logic                 done
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 2);

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_e;

  state_e        state_q;
  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] j_q;
  logic [AW-1:0] pass_q;
  logic          swap_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] j_d;
  logic [W-1:0]  cmp_lo;
  logic [W-1:0]  cmp_hi;
  logic          cmp_gt;
`ifdef SOSANH_SWAP_CNT_EN
  logic [7:0]    cnt_q;
`endif

  always_comb begin
    j_d    = j_q + AW'(1);
    cmp_lo = mem_q[j_q];
    cmp_hi = mem_q[j_d];
    cmp_gt = cmp_lo > cmp_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
      j_q     <= '0;
      pass_q  <= '0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SOSANH_SWAP_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (wr_en && int'(wr_addr) < N) mem_q[wr_addr] <= wr_data;
          if (start) begin
            state_q <= S_SORT;
            busy_q  <= 1'b1;
            j_q     <= '0;
            pass_q  <= '0;
            swap_q  <= 1'b0;
`ifdef SOSANH_SWAP_CNT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_SORT: begin
          if (cmp_gt) begin
            mem_q[j_q] <= cmp_hi;
            mem_q[j_d] <= cmp_lo;
`ifdef SOSANH_SWAP_CNT_EN
            cnt_q      <= cnt_q + 8'd1;
`endif
          end
          // End of pass: the final compare's swap counts toward the early-exit test.
          if (j_q == LAST) begin
            if (!(swap_q || cmp_gt) || pass_q == LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pass_q <= pass_q + AW'(1);
              j_q    <= '0;
              swap_q <= 1'b0;
            end
          end else begin
            j_q    <= j_d;
            swap_q <= swap_q | cmp_gt;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = (int'(rd_addr) < N) ? mem_q[rd_addr] : '0;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef SOSANH_SWAP_CNT_EN
  assign swap_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sosanh_sort_ctrl.sv
// Randomised bench for sosanh_sort_ctrl against a sorted-queue / inversion-count model.
module tb_sosanh_sort_ctrl;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
`ifdef SOSANH_SWAP_CNT_EN
  logic [7:0]    swap_cnt;
`endif

  sosanh_sort_ctrl #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
`ifdef SOSANH_SWAP_CNT_EN
    .swap_cnt (swap_cnt),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cur [N];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("%s rd[%0d]", tag, i), rd_data, 0);
    end
  endtask

  // Expected results come from a sorted copy plus inversion counts:
  // passes = 1 + max(larger elements to the left of any entry), capped at N-1.
  task automatic run_sort(input string tag, input bit disturb, input bit last_with_start);
    int q[$];
    int unsigned inv, maxl, l, passes, exp_busy;
    int unsigned busy_cnt, done_cnt, overlap, cyc;
    q.delete();
    inv  = 0;
    maxl = 0;
    for (int i = 0; i < N; i++) begin
      q.push_back(cur[i]);
      l = 0;
      for (int k = 0; k < i; k++) if (cur[k] > cur[i]) l++;
      inv += l;
      if (l > maxl) maxl = l;
    end
    q.sort();
    passes   = (maxl + 1 > N - 1) ? N - 1 : maxl + 1;
    exp_busy = passes * (N - 1);

    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = W'(cur[i]);
      if (i == N - 1 && last_with_start) start = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    if (!last_with_start) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    busy_cnt = 0;
    done_cnt = 0;
    overlap  = 0;
    cyc      = 0;
    while (cyc < 400) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (busy && done) overlap++;
      if (done_cnt > 0 && !done && !busy) break;
      if (disturb && cyc == 2) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = W'(9);
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, " in_time"}, (cyc < 400) ? 1 : 0, 1);
    check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_done_overlap"}, overlap, 0);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("%s rd[%0d]", tag, i), rd_data, q[i]);
    end
`ifdef SOSANH_SWAP_CNT_EN
    check({tag, " swap_cnt"}, swap_cnt, inv);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
`ifdef SOSANH_SWAP_CNT_EN
    check("reset swap_cnt", swap_cnt, 0);
`endif
    read_all_zero("reset");
    @(negedge clk);

    cur = '{7, 6, 5, 4, 3, 2, 1, 0};
    run_sort("reversed", 1'b0, 1'b0);
    cur = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_sort("sorted", 1'b0, 1'b0);
    cur = '{5, 5, 3, 3, 15, 0, 15, 0};
    run_sort("dups", 1'b0, 1'b0);
    cur = '{5, 5, 3, 3, 15, 0, 15, 0};
    run_sort("disturbed", 1'b1, 1'b0);
    cur = '{15, 15, 15, 15, 15, 15, 15, 15};
    run_sort("all_equal", 1'b0, 1'b1);

    // Reset asserted asynchronously in the 4th busy cycle.
    for (int i = 0; i < N; i++) cur[i] = int'($urandom_range(15, 0));
    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = W'(cur[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    read_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst busy", busy, 0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++)
        cur[i] = (t % 2 == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(3, 0));
      run_sort($sformatf("rand%0d", t), (t % 5 == 3) ? 1'b1 : 1'b0, ($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sosanh_sort_ctrl.md
Name: sosanh_sort_ctrl

Overview:
- Sequencer that sorts a small register file of W-bit values in place, ascending.
- Uses one shared W-bit magnitude comparator (gt/lt/eq) over successive adjacent pairs, bubble-sort style.
- Sits between a host that loads and reads values and the single comparator resource.
- Start/busy/done handshake; results read back through a read port.

Parameters:
- N, 8, number of entries; legal range 2..16.
- W, 4, data width of each entry in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the register file; honoured only in IDLE.
- wr_addr  in  clog2(N)  write index.
- wr_data  in  W  write value.
- start  in  1  request a sort; sampled only in IDLE.
- rd_addr  in  clog2(N)  read index.
- rd_data  out  W  combinational read of entry rd_addr.
- busy  out  1  high while the sort is in progress.
- done  out  1  one-cycle pulse when the sort completes.

Behaviour:
- Reset (async, any time, including mid-sort):
  - state=IDLE; all entries=0; busy=0; done=0; pair index j=0; pass count=0; swap flag=0.
  - rd_data therefore reads 0.
- States: IDLE, SORT, DONE.
- IDLE:
  - wr_en writes wr_data to entry wr_addr at the clock edge.
  - If wr_en and start are high in the same cycle, the write commits and the sort starts on the same edge; the sort sees the written value.
  - start=1 moves to SORT with j=0, pass=0, swap flag=0.
- SORT (busy=1): one compare per cycle on entries j and j+1.
  - If entry[j] > entry[j+1], swap them at the edge and set the swap flag.
  - Equal or less: no swap, so equal values are never exchanged.
  - j increments from 0 to N-2.
  - At j=N-2, the pass ends. Go to DONE if either:
    - no swap occurred in this pass (including the final compare), or
    - pass = N-2, i.e. N-1 passes have been completed.
  - Otherwise pass+1, j=0, clear the swap flag and stay in SORT.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Latency:
  - start edge to first compare = 1 cycle.
  - Busy cycles = (N-1) × passes executed.
  - Best case N-1; worst case (N-1)².
- Ignored inputs:
  - wr_en during SORT or DONE is dropped.
  - start during SORT or DONE is dropped and is not queued.
- rd_data is valid at any time. During SORT it shows intermediate contents.
- Widths: comparison is unsigned W-bit. j and pass counters are clog2(N) bits; neither wraps past N-2.

Optional Feature:
- Macro: SOSANH_SWAP_CNT_EN
- Defined:
  - Adds output swap_cnt (8 bits).
  - Cleared to 0 on reset and on an accepted start.
  - Increments once per swap.
  - Holds its value after done until the next accepted start.
  - Maximum value N(N-1)/2 = 120 at N=16, so it never overflows.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then read all 8 addresses -> rd_data=0 each; busy=0, done=0.
- Load 7,6,5,4,3,2,1,0 and pulse start -> 49 busy cycles, then a done pulse; contents read 0..7; swap_cnt=28 (macro on).
- Load 0..7 and start -> 7 busy cycles, done; contents unchanged; swap_cnt=0.
- Load 5,5,3,3,F,0,F,0 and start -> final contents 0,0,3,3,5,5,F,F; done asserted exactly once.
- During SORT, pulse start and write 9 to addr 0 -> no restart, write dropped; result matches the undisturbed sort.
- Assert rst mid-sort (4th busy cycle) -> busy=0 immediately and all entries read 0. A new load plus start then sorts correctly.
